uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer placed directly downstream of `UART_Receiver`. It captures each byte the receiver presents on `RX_DATA` when `RX_STATUS` rises, stores it in a small circular FIFO, and hands bytes to the CPU peripheral bus through a registered pop handshake. It also reports fill level and a sticky overflow flag. This decouples serial arrival timing from CPU polling latency.

## Interface
Parameters:
- `DEPTH`, 8: number of byte entries; must be a power of two, ≥ 2.
- `AW`, 3: pointer width, equal to log2(`DEPTH`).

Ports:
- `sysclk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `RX_STATUS`  in  1  receiver byte-valid. May be a one-cycle pulse or a held level; only its rising edge matters.
- `RX_DATA`  in  8  received byte; stable in the cycle `RX_STATUS` rises.
- `rd_en`  in  1  CPU pop request, sampled each cycle.
- `ovf_clr`  in  1  clears `overflow`.
- `rd_data`  out  8  popped byte; holds its value until the next pop.
- `rd_valid`  out  1  one-cycle strobe: `rd_data` was updated this cycle.
- `empty`  out  1  level == 0.
- `full`  out  1  level == `DEPTH`.
- `level`  out  AW+1  number of stored bytes, 0..`DEPTH`.
- `overflow`  out  1  sticky; a byte was dropped.

## Operation
- Edge detector: `stat_q` registers `RX_STATUS`. A push event is `RX_STATUS & ~stat_q`.
- Push: on a push event, when not full or when a pop is accepted in the same cycle, `RX_DATA` is written at `wptr` and `wptr` increments.
- Pop: accepted when `rd_en` is high and `empty` is low. `mem[rptr]` goes to `rd_data`, `rptr` increments, and `rd_valid` pulses.
- `rd_en` while empty is ignored: no `rd_valid`, `rd_data` unchanged.
- Pointers are AW bits and wrap modulo `DEPTH`. `level` is a separate counter: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Push when full with no accepted pop: the byte is dropped, pointers and level are unchanged, and `overflow` is set.
- Push and pop in the same cycle:
  - Full: both proceed; level stays at `DEPTH`; no overflow.
  - Empty: the pop is ignored (no fall-through) and the push proceeds.
- `ovf_clr` clears `overflow` on the next edge. If a new overflow occurs in the same cycle, set wins.
- Reset: pointers = 0, `level` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `rd_valid` = 0, `rd_data` = 8'h00. `stat_q` = 1, so a `RX_STATUS` level already high at reset release does not produce a push. Memory contents are not reset.
- `empty`, `full` and `level` are registered, or derived combinationally from the registered `level` only.

## Timing
- Push latency: `RX_STATUS` rises in cycle N; the byte is written at edge N. `empty` falls and `level` increments in cycle N+1.
- Pop latency: `rd_en` is sampled high in cycle N with `empty` low; `rd_data` and `rd_valid` are valid in cycle N+1. `level` decrements in N+1.
- Back-to-back: `rd_en` held high pops one byte per cycle until empty. A byte pushed in cycle N is poppable in N+1 at the earliest.
- A held `RX_STATUS` level produces exactly one push. It must drop for at least one cycle before the next push can occur.
- Reset asserted mid-operation: all state returns to reset values on that edge. Stored bytes are logically discarded.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_DATA_W` = 8;
  - `UART_RXFIFO_DEPTH` = 8;
  - a `uart_byte_t` typedef.
- One sub-module, `uart_fifo_mem`: a `DEPTH`×8 register array with a synchronous write port and a read port addressed by `rptr`. It has no reset and is reusable by a future transmit FIFO.
- Top level contains the edge detector, pointers, level counter, flags and read register.

## Test plan
- Reset, then push 8'hA5 via a one-cycle `RX_STATUS` pulse → `empty` = 0 and `level` = 1 in the next cycle. `rd_en` → `rd_data` = 8'hA5 and `rd_valid` = 1 one cycle later, then `empty` = 1.
- Hold `RX_STATUS` high for 5 cycles with `RX_DATA` = 8'h3C → exactly one push; `level` = 1.
- Push 8'h00..8'h07 → `full` = 1. Push 8'hFF → `overflow` = 1 and `level` = 8. Pop all 8 → 8'h00..8'h07 in order, 8'hFF absent. Assert `ovf_clr` → `overflow` = 0.
- Fill to 8, then push 8'h55 and pop in the same cycle → popped 8'h00, `level` stays 8, no overflow, 8'h55 later read last.
- Push 12 and pop 12 interleaved across the wrap boundary → data order preserved, `level` correct every cycle. `rd_en` while empty → no `rd_valid`, `rd_data` held.
- Assert `reset` with `level` = 4 and `RX_STATUS` high → all outputs at reset values. Release with `RX_STATUS` still high → no push.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths, FIFO depth and byte type
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_RXFIFO_DEPTH = 8;
  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x byte register array, synchronous write, asynchronous read
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RXFIFO_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  uart_byte_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output uart_byte_t    rdata_o
);
  uart_byte_t mem_q [DEPTH];
  always_ff @(posedge clk_i) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes on RX_STATUS rising edges into a circular FIFO
// and returns them through a registered pop with level and sticky overflow flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RXFIFO_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        RX_STATUS,
  input  uart_byte_t  RX_DATA,
  input  logic        rd_en,
  input  logic        ovf_clr,
  output uart_byte_t  rd_data,
  output logic        rd_valid,
  output logic        empty,
  output logic        full,
  output logic [AW:0] level,
  output logic        overflow
);
  logic          stat_q;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d, rd_valid_q, rd_valid_d;
  uart_byte_t    rd_data_q, rd_data_d, mem_rd;
  logic          push_ev, push, pop;
  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i  (sysclk),
    .we_i   (push),
    .waddr_i(wptr_q),
    .wdata_i(RX_DATA),
    .raddr_i(rptr_q),
    .rdata_o(mem_rd)
  );
  assign empty = level_q == '0;
  assign full = level_q == (AW+1)'(DEPTH);
  always_comb begin
    push_ev = RX_STATUS & ~stat_q;
    pop = rd_en & ~empty;
    // a full FIFO still accepts a push when the same cycle frees a slot
    push = push_ev & (~full | pop);
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = (push_ev & full & ~pop) | (ovf_q & ~ovf_clr);
    rd_data_d = pop ? mem_rd : rd_data_q;
    rd_valid_d = pop;
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      stat_q <= 1'b1;
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      stat_q <= RX_STATUS;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign level = level_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table vectors, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_uart_rx_fifo;
  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       RX_STATUS = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, empty, full, overflow;
  logic [3:0] level;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] m_q[$];
  bit         m_stat = 1'b1;
  bit         m_ovf = 1'b0;
  bit         m_rv = 1'b0;
  logic [7:0] m_rdd = 8'h00;

  uart_rx_fifo dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .RX_STATUS(RX_STATUS),
    .RX_DATA  (RX_DATA),
    .rd_en    (rd_en),
    .ovf_clr  (ovf_clr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .overflow (overflow)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the reference model, compare every output.
  task automatic cycle(input logic rs, input logic [7:0] d, input logic rd,
                       input logic clr, input logic rst);
    bit pe, popok, was_full;
    RX_STATUS = rs; RX_DATA = d; rd_en = rd; ovf_clr = clr; reset = rst;
    @(posedge sysclk);
    if (rst) begin
      m_q.delete(); m_stat = 1'b1; m_ovf = 1'b0; m_rv = 1'b0; m_rdd = 8'h00;
    end else begin
      pe = rs && !m_stat;
      popok = rd && m_q.size() > 0;
      was_full = m_q.size() == 8;
      m_rv = popok;
      if (popok) m_rdd = m_q.pop_front();
      if (pe && (!was_full || popok)) m_q.push_back(d);
      if (pe && was_full && !popok) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_stat = rs;
    end
    #1;
    check("model_level", 32'(level), 32'(m_q.size()));
    check("model_empty", 32'(empty), 32'(m_q.size() == 0));
    check("model_full", 32'(full), 32'(m_q.size() == 8));
    check("model_overflow", 32'(overflow), 32'(m_ovf));
    check("model_rd_valid", 32'(rd_valid), 32'(m_rv));
    check("model_rd_data", 32'(rd_data), 32'(m_rdd));
  endtask

  task automatic push(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic rst, rs;
    logic [7:0] d;
    logic rd, clr;
    int lvl;
    logic emp, ful, ovf, rv;
    logic [7:0] rdd;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    for (int i = 5; i < 10; i++)
      vecs[i] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[13] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77};

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].rs, vecs[i].d, vecs[i].rd, vecs[i].clr, vecs[i].rst);
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].ful));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
      check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rdd));
    end

    // Overflow: fill, drop 8'hFF, drain in order, then clear the flag.
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(i));
    check("fill_full", 32'(full), 32'd1);
    push(8'hFF);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      pop();
      check("drain_data", 32'(rd_data), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(i));
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("fullpp_data", 32'(rd_data), 32'h00);
    check("fullpp_level", 32'(level), 32'd8);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pop();
    check("fullpp_last", 32'(rd_data), 32'h55);
    pop();
    check("empty_rd_valid", 32'(rd_valid), 32'd0);
    check("empty_rd_hold", 32'(rd_data), 32'h55);

    // Interleaved push/pop across the pointer wrap.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // Reset mid-operation with RX_STATUS held high through release.
    do_reset();
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    check("pre_rst_level", 32'(level), 32'd4);
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    check("rst_release_nopush", 32'(level), 32'd0);

    // Random traffic: push-heavy then pop-heavy phases to visit full and empty.
    for (int i = 0; i < 3000; i++) begin
      int rd_pct;
      rd_pct = ((i / 300) % 2 == 0) ? 20 : 80;
      cycle(1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 99) < rd_pct), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 499) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
